// File: rtl/core_pkg.sv
// Shared core definitions: access-size and write-back-source encodings,
// default datapath width and the byte-lane helper.
package core_pkg;

  localparam int XLEN_DEF = 32;

  // funct3[1:0] access size
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  // write-back source select
  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;

  // number of byte lanes in an xlen-wide word
  function automatic int lanes(input int xlen);
    return xlen / 8;
  endfunction

endpackage

// File: rtl/store_align_unit.sv
// Combinational lane aligner: replicates the access-sized chunk of data
// across all lanes, builds the byte enables for the addressed lanes and
// flags misaligned or unsupported sizes. On a flagged access the byte
// enables are 0 and the data is passed through untouched.
module store_align_unit
  import core_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [1:0]                   size,
  input  logic [$clog2(XLEN/8)-1:0]    off,
  input  logic [XLEN-1:0]              data,
  output logic [XLEN-1:0]              data_out,
  output logic [XLEN/8-1:0]            byte_en,
  output logic                         misalign
);

  localparam int LANES = lanes(XLEN);

  localparam logic [LANES-1:0] BE_B = LANES'(1);
  localparam logic [LANES-1:0] BE_H = LANES'(3);
  localparam logic [LANES-1:0] BE_W = LANES'(15);

  // size decode, alignment test and lane replication
  always_comb begin
    data_out = data;
    byte_en  = '0;
    misalign = 1'b0;
    case (size)
      SZ_B: begin
        byte_en  = BE_B << off;
        data_out = {(LANES){data[7:0]}};
      end
      SZ_H: begin
        if (off[0]) begin
          misalign = 1'b1;
        end else begin
          byte_en  = BE_H << off;
          data_out = {(LANES/2){data[15:0]}};
        end
      end
      SZ_W: begin
        if (off[1:0] != 2'b00) begin
          misalign = 1'b1;
        end else begin
          byte_en  = BE_W << off;
          data_out = {(XLEN/32){data[31:0]}};
        end
      end
      SZ_D: begin
        // doubleword exists only on a 64-bit datapath at offset 0
        if ((XLEN == 64) && (off == '0)) begin
          byte_en = '1;
        end else begin
          misalign = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register. One-cycle registered transfer with
// flush > stall > load priority, valid gating of controls, store/load lane
// alignment with misalignment squash, and a saturating bubble counter.
module ex_mem_stage_reg
  import core_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int RA_W     = 5,
  parameter int ALIGN_EN = 1,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall_m,
  input  logic                flush_m,
  input  logic                valid_e,
  input  logic                reg_write_e,
  input  logic [1:0]          result_src_e,
  input  logic                mem_write_e,
  input  logic                mem_read_e,
  input  logic [2:0]          funct3_e,
  input  logic [XLEN-1:0]     alu_result_e,
  input  logic [XLEN-1:0]     write_data_e,
  input  logic [RA_W-1:0]     rd_e,
  input  logic [XLEN-1:0]     pc_plus4_e,
  output logic                valid_m,
  output logic                reg_write_m,
  output logic                mem_write_m,
  output logic                mem_read_m,
  output logic [1:0]          result_src_m,
  output logic [2:0]          funct3_m,
  output logic [XLEN-1:0]     alu_result_m,
  output logic [XLEN-1:0]     write_data_m,
  output logic [XLEN/8-1:0]   byte_en_m,
  output logic [RA_W-1:0]     rd_m,
  output logic [XLEN-1:0]     pc_plus4_m,
  output logic                misalign_m,
  output logic [CNT_W-1:0]    bubble_cnt
);

  localparam int LANES = lanes(XLEN);
  localparam int OFF_W = $clog2(LANES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             mem_acc;
  logic             mis_n;
  logic [LANES-1:0] be_n;
  logic [XLEN-1:0]  wd_n;
  logic             bubble;

  assign mem_acc = mem_write_e | mem_read_e;

  if (ALIGN_EN != 0) begin : g_align
    logic [XLEN-1:0]  al_data;
    logic [LANES-1:0] al_be;
    logic             al_mis;

    store_align_unit #(.XLEN(XLEN)) u_align (
      .size     (funct3_e[1:0]),
      .off      (alu_result_e[OFF_W-1:0]),
      .data     (write_data_e),
      .data_out (al_data),
      .byte_en  (al_be),
      .misalign (al_mis)
    );

    // misalignment only matters for a real memory instruction
    assign mis_n = mem_acc & valid_e & al_mis;
    assign be_n  = mem_acc ? al_be : '0;
    assign wd_n  = mem_acc ? al_data : write_data_e;
  end else begin : g_pass
    assign mis_n = 1'b0;
    assign be_n  = mem_write_e ? '1 : '0;
    assign wd_n  = write_data_e;
  end

  // a bubble is loaded by a flush or by a load of an empty EX slot
  assign bubble = flush_m | (~stall_m & ~valid_e);

  // stage register: flush clears, stall holds, otherwise load gated by valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_m      <= 1'b0;
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      mem_read_m   <= 1'b0;
      result_src_m <= '0;
      funct3_m     <= '0;
      alu_result_m <= '0;
      write_data_m <= '0;
      byte_en_m    <= '0;
      rd_m         <= '0;
      pc_plus4_m   <= '0;
      misalign_m   <= 1'b0;
    end else if (flush_m) begin
      valid_m      <= 1'b0;
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      mem_read_m   <= 1'b0;
      result_src_m <= '0;
      funct3_m     <= '0;
      alu_result_m <= '0;
      write_data_m <= '0;
      byte_en_m    <= '0;
      rd_m         <= '0;
      pc_plus4_m   <= '0;
      misalign_m   <= 1'b0;
    end else if (!stall_m) begin
      valid_m      <= valid_e;
      reg_write_m  <= valid_e & reg_write_e;
      mem_write_m  <= valid_e & mem_write_e & ~mis_n;
      mem_read_m   <= valid_e & mem_read_e & ~mis_n;
      result_src_m <= result_src_e;
      funct3_m     <= funct3_e;
      alu_result_m <= alu_result_e;
      write_data_m <= wd_n;
      byte_en_m    <= be_n;
      rd_m         <= rd_e;
      pc_plus4_m   <= pc_plus4_e;
      misalign_m   <= mis_n;
    end
  end

  // saturating count of bubbles entering MEM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (bubble && (bubble_cnt != CNT_MAX)) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Bench for ex_mem_stage_reg: three instances (32-bit with a 2-bit counter,
// 64-bit, 32-bit without alignment) share one directed stimulus stream.
// A lane-level model predicts every output each cycle; literal checks pin
// hand-computed values.
module tb_ex_mem_stage_reg;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic        mw;
    logic        mr;
    logic [1:0]  rs;
    logic [2:0]  f3;
    logic [63:0] alu;
    logic [63:0] wd;
    logic [7:0]  be;
    logic [4:0]  rd;
    logic [63:0] pc;
    logic        mis;
    logic [15:0] cnt;
  } out_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus
  logic        stall_m = 0, flush_m = 0, valid_e = 0, reg_write_e = 0;
  logic        mem_write_e = 0, mem_read_e = 0;
  logic [1:0]  result_src_e = 0;
  logic [2:0]  funct3_e = 0;
  logic [63:0] alu_result_e = 0, write_data_e = 0, pc_plus4_e = 0;
  logic [4:0]  rd_e = 0;

  int errors = 0;
  int checks = 0;

  // instance outputs
  logic o32_valid, o32_rw, o32_mw, o32_mr, o32_mis;
  logic [1:0] o32_rs; logic [2:0] o32_f3; logic [31:0] o32_alu, o32_wd, o32_pc;
  logic [3:0] o32_be; logic [4:0] o32_rd; logic [1:0] o32_cnt;

  logic o64_valid, o64_rw, o64_mw, o64_mr, o64_mis;
  logic [1:0] o64_rs; logic [2:0] o64_f3; logic [63:0] o64_alu, o64_wd, o64_pc;
  logic [7:0] o64_be; logic [4:0] o64_rd; logic [15:0] o64_cnt;

  logic ona_valid, ona_rw, ona_mw, ona_mr, ona_mis;
  logic [1:0] ona_rs; logic [2:0] ona_f3; logic [31:0] ona_alu, ona_wd, ona_pc;
  logic [3:0] ona_be; logic [4:0] ona_rd; logic [15:0] ona_cnt;

  ex_mem_stage_reg #(.XLEN(32), .RA_W(5), .ALIGN_EN(1), .CNT_W(2)) d32 (
    .clk(clk), .rst_n(rst_n), .stall_m(stall_m), .flush_m(flush_m),
    .valid_e(valid_e), .reg_write_e(reg_write_e), .result_src_e(result_src_e),
    .mem_write_e(mem_write_e), .mem_read_e(mem_read_e), .funct3_e(funct3_e),
    .alu_result_e(alu_result_e[31:0]), .write_data_e(write_data_e[31:0]),
    .rd_e(rd_e), .pc_plus4_e(pc_plus4_e[31:0]),
    .valid_m(o32_valid), .reg_write_m(o32_rw), .mem_write_m(o32_mw),
    .mem_read_m(o32_mr), .result_src_m(o32_rs), .funct3_m(o32_f3),
    .alu_result_m(o32_alu), .write_data_m(o32_wd), .byte_en_m(o32_be),
    .rd_m(o32_rd), .pc_plus4_m(o32_pc), .misalign_m(o32_mis), .bubble_cnt(o32_cnt)
  );

  ex_mem_stage_reg #(.XLEN(64), .RA_W(5), .ALIGN_EN(1), .CNT_W(16)) d64 (
    .clk(clk), .rst_n(rst_n), .stall_m(stall_m), .flush_m(flush_m),
    .valid_e(valid_e), .reg_write_e(reg_write_e), .result_src_e(result_src_e),
    .mem_write_e(mem_write_e), .mem_read_e(mem_read_e), .funct3_e(funct3_e),
    .alu_result_e(alu_result_e), .write_data_e(write_data_e),
    .rd_e(rd_e), .pc_plus4_e(pc_plus4_e),
    .valid_m(o64_valid), .reg_write_m(o64_rw), .mem_write_m(o64_mw),
    .mem_read_m(o64_mr), .result_src_m(o64_rs), .funct3_m(o64_f3),
    .alu_result_m(o64_alu), .write_data_m(o64_wd), .byte_en_m(o64_be),
    .rd_m(o64_rd), .pc_plus4_m(o64_pc), .misalign_m(o64_mis), .bubble_cnt(o64_cnt)
  );

  ex_mem_stage_reg #(.XLEN(32), .RA_W(5), .ALIGN_EN(0), .CNT_W(16)) dna (
    .clk(clk), .rst_n(rst_n), .stall_m(stall_m), .flush_m(flush_m),
    .valid_e(valid_e), .reg_write_e(reg_write_e), .result_src_e(result_src_e),
    .mem_write_e(mem_write_e), .mem_read_e(mem_read_e), .funct3_e(funct3_e),
    .alu_result_e(alu_result_e[31:0]), .write_data_e(write_data_e[31:0]),
    .rd_e(rd_e), .pc_plus4_e(pc_plus4_e[31:0]),
    .valid_m(ona_valid), .reg_write_m(ona_rw), .mem_write_m(ona_mw),
    .mem_read_m(ona_mr), .result_src_m(ona_rs), .funct3_m(ona_f3),
    .alu_result_m(ona_alu), .write_data_m(ona_wd), .byte_en_m(ona_be),
    .rd_m(ona_rd), .pc_plus4_m(ona_pc), .misalign_m(ona_mis), .bubble_cnt(ona_cnt)
  );

  out_t a32, a64, ana;
  assign a32 = {o32_valid, o32_rw, o32_mw, o32_mr, o32_rs, o32_f3, 64'(o32_alu),
                64'(o32_wd), 8'(o32_be), o32_rd, 64'(o32_pc), o32_mis, 16'(o32_cnt)};
  assign a64 = {o64_valid, o64_rw, o64_mw, o64_mr, o64_rs, o64_f3, o64_alu,
                o64_wd, o64_be, o64_rd, o64_pc, o64_mis, o64_cnt};
  assign ana = {ona_valid, ona_rw, ona_mw, ona_mr, ona_rs, ona_f3, 64'(ona_alu),
                64'(ona_wd), 8'(ona_be), ona_rd, 64'(ona_pc), ona_mis, ona_cnt};

  // ---------------- model ----------------
  // What the stage captures from the current EX inputs, lane by lane.
  function automatic out_t model_load(input int xlen, input bit aen);
    out_t o;
    int nb, off, ln;
    bit legal;
    logic [63:0] m;
    o  = '0;
    ln = xlen / 8;
    m  = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    o.valid = valid_e;
    o.rw    = valid_e & reg_write_e;
    o.rs    = result_src_e;
    o.f3    = funct3_e;
    o.alu   = alu_result_e & m;
    o.wd    = write_data_e & m;
    o.rd    = rd_e;
    o.pc    = pc_plus4_e & m;
    if (!aen) begin
      o.mw = valid_e & mem_write_e;
      o.mr = valid_e & mem_read_e;
      o.be = mem_write_e ? 8'((1 << ln) - 1) : 8'h00;
    end else if (mem_write_e || mem_read_e) begin
      nb    = 1 << funct3_e[1:0];
      off   = int'(alu_result_e[2:0]) % ln;
      legal = (nb <= ln) && ((off % nb) == 0);
      if (legal) begin
        o.be = 8'(((1 << nb) - 1) << off);
        for (int i = 0; i < ln; i++) o.wd[8*i +: 8] = write_data_e[8*(i % nb) +: 8];
      end
      o.mis = valid_e & !legal;
      o.mw  = valid_e & mem_write_e & legal;
      o.mr  = valid_e & mem_read_e & legal;
    end
    return o;
  endfunction

  function automatic out_t model_step(input out_t cur, input int xlen, input bit aen,
                                      input logic [15:0] maxc);
    out_t o;
    bit bub;
    if (flush_m) begin
      o = '0; bub = 1;
    end else if (stall_m) begin
      o = cur; bub = 0;
    end else begin
      o = model_load(xlen, aen); bub = !valid_e;
    end
    o.cnt = (bub && cur.cnt != maxc) ? cur.cnt + 16'd1 : cur.cnt;
    return o;
  endfunction

  out_t e32 = '0, e64 = '0, ena = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e32 = '0; e64 = '0; ena = '0;
    end else begin
      e32 = model_step(e32, 32, 1'b1, 16'd3);
      e64 = model_step(e64, 64, 1'b1, 16'hFFFF);
      ena = model_step(ena, 32, 1'b0, 16'hFFFF);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // every-cycle comparison of all three instances against the model
  always @(negedge clk) begin
    chk("cyc_d32", a32, e32);
    chk("cyc_d64", a64, e64);
    chk("cyc_dna", ana, ena);
  end

  // ---------------- driver ----------------
  task automatic drive(input logic v, rw, mw, mr, input logic [2:0] f3,
                       input logic [63:0] addr, wd, input logic [4:0] rd);
    valid_e = v; reg_write_e = rw; mem_write_e = mw; mem_read_e = mr;
    funct3_e = f3; alu_result_e = addr; write_data_e = wd; rd_e = rd;
    result_src_e = mr ? 2'd1 : 2'd0;
    pc_plus4_e = addr + 64'd4;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset with every input nonzero
    drive(1, 1, 1, 1, 3'b010, 64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31);
    #3;
    chk("rst_d32", a32, '0);
    chk("rst_d64", a64, '0);
    chk("rst_dna", ana, '0);
    @(negedge clk); #2;
    rst_n = 1'b1;

    drive(1, 0, 0, 0, 3'b000, 64'h100, 64'h0, 5'd5);
    cyc();
    lit("first_valid", 64'(o32_valid), 64'd1);
    lit("first_rd", 64'(o32_rd), 64'd5);

    // SB at offset 3
    drive(1, 0, 1, 0, 3'b000, 64'h1003, 64'hAB, 5'd1);
    cyc();
    lit("sb_be32", 64'(o32_be), 64'h8);
    lit("sb_wd32", 64'(o32_wd), 64'hABAB_ABAB);
    lit("sb_mis32", 64'(o32_mis), 64'd0);
    lit("sb_be64", 64'(o64_be), 64'h08);
    lit("sb_wd64", o64_wd, 64'hABAB_ABAB_ABAB_ABAB);
    lit("sb_bena", 64'(ona_be), 64'hF);

    // SH misaligned
    drive(1, 0, 1, 0, 3'b001, 64'h1001, 64'h1234, 5'd2);
    cyc();
    lit("sh_mis32", 64'(o32_mis), 64'd1);
    lit("sh_mw32", 64'(o32_mw), 64'd0);
    lit("sh_be32", 64'(o32_be), 64'h0);
    lit("sh_misna", 64'(ona_mis), 64'd0);

    // SW aligned
    drive(1, 0, 1, 0, 3'b010, 64'h1000, 64'hCAFE_F00D, 5'd3);
    cyc();
    lit("sw_be32", 64'(o32_be), 64'hF);
    lit("sw_mis32", 64'(o32_mis), 64'd0);
    lit("sw_wd32", 64'(o32_wd), 64'hCAFE_F00D);

    // stall three cycles with changing inputs
    stall_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 1, 3'b001, 64'h2000 + 64'(i * 2), 64'(i), 5'd7);
      cyc();
    end
    lit("stall_alu32", 64'(o32_alu), 64'h1000);
    lit("stall_wd32", 64'(o32_wd), 64'hCAFE_F00D);
    lit("stall_cnt32", 64'(o32_cnt), 64'd0);

    // flush wins over stall
    flush_m = 1'b1;
    cyc();
    lit("flush_valid32", 64'(o32_valid), 64'd0);
    lit("flush_alu32", 64'(o32_alu), 64'd0);
    lit("flush_cnt32", 64'(o32_cnt), 64'd1);
    lit("flush_cnt64", 64'(o64_cnt), 64'd1);
    flush_m = 1'b0;
    stall_m = 1'b0;

    // invalid slot: controls gated, data loads
    drive(0, 1, 1, 0, 3'b010, 64'h3000, 64'h55, 5'd9);
    cyc();
    lit("inv_rw32", 64'(o32_rw), 64'd0);
    lit("inv_mw32", 64'(o32_mw), 64'd0);
    lit("inv_rd32", 64'(o32_rd), 64'd9);
    lit("inv_alu32", 64'(o32_alu), 64'h3000);
    lit("inv_cnt32", 64'(o32_cnt), 64'd2);

    // five more bubbles: 2-bit counter saturates
    repeat (5) cyc();
    lit("sat_cnt32", 64'(o32_cnt), 64'd3);
    lit("sat_cnt64", 64'(o64_cnt), 64'd7);

    // SD
    drive(1, 1, 1, 0, 3'b011, 64'h8, 64'h1122_3344_5566_7788, 5'd4);
    cyc();
    lit("sd_be64", 64'(o64_be), 64'hFF);
    lit("sd_wd64", o64_wd, 64'h1122_3344_5566_7788);
    lit("sd_mis64", 64'(o64_mis), 64'd0);
    lit("sd_mis32", 64'(o32_mis), 64'd1);
    lit("sd_mw32", 64'(o32_mw), 64'd0);
    lit("sd_be32", 64'(o32_be), 64'h0);

    // LHU at offset 6
    drive(1, 1, 0, 1, 3'b101, 64'h1006, 64'hBEEF, 5'd6);
    cyc();
    lit("lh_be32", 64'(o32_be), 64'hC);
    lit("lh_wd32", 64'(o32_wd), 64'hBEEF_BEEF);
    lit("lh_be64", 64'(o64_be), 64'hC0);
    lit("lh_bena", 64'(ona_be), 64'h0);

    // LW at offset 4
    drive(1, 1, 0, 1, 3'b010, 64'h1004, 64'hDEAD_BEEF, 5'd8);
    cyc();
    lit("lw_be64", 64'(o64_be), 64'hF0);
    lit("lw_wd64", o64_wd, 64'hDEAD_BEEF_DEAD_BEEF);
    lit("lw_be32", 64'(o32_be), 64'hF);

    // non-memory instruction
    drive(1, 1, 0, 0, 3'b000, 64'h1003, 64'h77, 5'd10);
    cyc();
    lit("alu_be32", 64'(o32_be), 64'h0);
    lit("alu_wd32", 64'(o32_wd), 64'h77);
    lit("alu_pc32", 64'(o32_pc), 64'h1007);

    // asynchronous reset during a stall
    stall_m = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_d32", a32, '0);
    chk("arst_d64", a64, '0);
    chk("arst_dna", ana, '0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    stall_m = 1'b0;

    drive(1, 1, 1, 0, 3'b000, 64'h2002, 64'h5A, 5'd12);
    cyc();
    drive(1, 0, 1, 0, 3'b001, 64'h2006, 64'h9876, 5'd13);
    cyc();
    drive(0, 0, 0, 0, 3'b000, 64'h0, 64'h0, 5'd0);
    repeat (2) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage_reg.md
Name: ex_mem_stage_reg

Overview:
Parametrised EX/MEM pipeline register for the RISC-V core. It sits between the ALU stage and the data-memory stage. On top of plain EX->MEM transfer it adds stall (hold), flush (bubble insertion), a valid bit, store/load byte-lane alignment, misalignment detection and a saturating bubble counter. It is generic over XLEN (32/64) and register-address width.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64.
RA_W, 5, register-file address width.
ALIGN_EN, 1, 1 = align store data and generate byte enables; 0 = pass write data through with all byte enables set and no misalignment check.
CNT_W, 16, width of the bubble counter.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous, active-low reset.
stall_m  in  1  hold all stage outputs.
flush_m  in  1  load a bubble.
valid_e  in  1  EX slot holds a real instruction.
reg_write_e  in  1  register write-back enable.
result_src_e  in  2  write-back source select.
mem_write_e  in  1  store.
mem_read_e  in  1  load.
funct3_e  in  3  access size/sign.
alu_result_e  in  XLEN  effective address / ALU result.
write_data_e  in  XLEN  unaligned store data (rs2, forwarded).
rd_e  in  RA_W  destination register.
pc_plus4_e  in  XLEN  PC+4 for JAL/JALR write-back.
valid_m, reg_write_m, mem_write_m, mem_read_m  out  1  registered controls.
result_src_m  out  2  registered.
funct3_m  out  3  registered.
alu_result_m  out  XLEN  registered.
write_data_m  out  XLEN  lane-aligned store data.
byte_en_m  out  XLEN/8  byte-lane enables.
rd_m  out  RA_W  registered.
pc_plus4_m  out  XLEN  registered.
misalign_m  out  1  misaligned or illegal-size memory access.
bubble_cnt  out  CNT_W  saturating bubble count.

Behaviour:
- rst_n low (asynchronous): every output goes to 0, including bubble_cnt. Reset mid-stall or mid-flush wins immediately.
- Update priority on each rising edge: flush_m > stall_m > load.
- flush_m=1: all outputs load 0, regardless of stall_m.
- stall_m=1 and flush_m=0: all outputs hold their values.
- Load (neither asserted):
  - Outputs take the _e inputs gated by valid_e.
  - When valid_e=0, every control output (valid, reg_write, mem_write, mem_read) loads 0. Data fields still load.
- Latency is exactly one cycle. There is no combinational path from input to output.
- Alignment (ALIGN_EN=1): OFF = alu_result_e[log2(XLEN/8)-1:0]. Applied on loads and stores.
  - funct3[1:0]=00 (byte): byte_en = 1<<OFF; data = byte replicated across all lanes.
  - 01 (half): requires OFF[0]=0; byte_en = 2'b11<<OFF; data = half replicated.
  - 10 (word): requires OFF[1:0]=0; byte_en = 4'hF<<OFF; data = word replicated (XLEN=64).
  - 11 (double): legal only when XLEN=64 and OFF=0; byte_en all ones. When XLEN=32 it is illegal.
- misalign_m=1 when (mem_write_e|mem_read_e) & valid_e & (requirement violated or illegal size).
  - In that case mem_write_m and mem_read_m are forced to 0 and byte_en_m is 0.
  - reg_write_m and rd_m pass through; the trap unit squashes them.
- Non-memory instructions: byte_en_m=0, misalign_m=0, write_data_m = write_data_e.
- ALIGN_EN=0: write_data_m = write_data_e; byte_en_m all ones when mem_write_e, else 0; misalign_m always 0.
- bubble_cnt: increments on each edge that loads a bubble (flush_m=1, or load with valid_e=0). It holds during stall and saturates at 2^CNT_W-1 with no wrap.

Decomposition:
- Shared package core_pkg holds:
  - funct3 size encodings (SZ_B=2'b00, SZ_H, SZ_W, SZ_D);
  - result_src encodings;
  - XLEN default and the function lanes(XLEN)=XLEN/8.
- One combinational sub-module, store_align_unit, takes funct3, OFF and data and returns aligned data, byte_en and misalign. It is reused by the later load-extend stage.

Test Plan:
1. rst_n=0 with all inputs nonzero -> all outputs 0 asynchronously. Release, valid_e=1, alu_result_e=0x100, rd_e=5 -> valid_m=1, rd_m=5 after one edge.
2. SB, alu_result_e=0x1003, write_data_e=0x000000AB -> byte_en_m=4'b1000, write_data_m=0xABABABAB, misalign_m=0.
3. SH at 0x1001 with mem_write_e=1 -> misalign_m=1, mem_write_m=0, byte_en_m=0. SW at 0x1000 -> byte_en_m=4'hF, misalign_m=0.
4. stall_m=1 for 3 cycles while inputs change -> outputs frozen and bubble_cnt unchanged. stall_m=1 with flush_m=1 -> all outputs 0 and bubble_cnt +1.
5. valid_e=0, reg_write_e=1, mem_write_e=1 -> reg_write_m=0, mem_write_m=0, bubble_cnt +1. With CNT_W=2, force 5 bubbles -> bubble_cnt stays at 3.
6. XLEN=64: SD at 0x8, data 0x1122334455667788 -> byte_en_m=8'hFF. XLEN=32: funct3=011 store -> misalign_m=1.
